// File: rtl/rl_ras_err_arb.sv
// ECC error event arbiter: per-source pending slots, fatal-first round-robin grant
// into a small FIFO feeding the RAS ECC counter/log. Optional macro: RL_RAS_ARB_TIMESTAMP_EN.
module rl_ras_err_arb #(
    parameter int NUM_SRC    = 5,
    parameter int SRC_W      = 3,
    parameter int ADDR_W     = 16,
    parameter int SYN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_a,
    input  logic [NUM_SRC-1:0]        src_sb_err,
    input  logic [NUM_SRC-1:0]        src_db_err,
    input  logic [NUM_SRC-1:0]        src_addr_err,
    input  logic [NUM_SRC*SYN_W-1:0]  src_syndrome,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    output logic                      evt_valid,
    input  logic                      evt_accept,
    output logic [SRC_W-1:0]          evt_src,
    output logic [1:0]                evt_type,
    output logic [SYN_W-1:0]          evt_syndrome,
    output logic [ADDR_W-1:0]         evt_addr,
`ifdef RL_RAS_ARB_TIMESTAMP_EN
    output logic [15:0]               evt_tstamp,
`endif
    output logic                      high_prio,
    output logic [7:0]                drop_cnt,
    input  logic                      drop_clr
);

    localparam logic [1:0] TYPE_SB   = 2'b01;
    localparam logic [1:0] TYPE_DB   = 2'b10;
    localparam logic [1:0] TYPE_ADDR = 2'b11;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int DSUM_W   = $clog2(NUM_SRC + 1);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [1:0]        etype;
        logic [SYN_W-1:0]  syn;
        logic [ADDR_W-1:0] addr;
`ifdef RL_RAS_ARB_TIMESTAMP_EN
        logic [15:0]       ts;
`endif
    } entry_t;

    entry_t               slot_q [NUM_SRC];
    logic [NUM_SRC-1:0]   slot_full_q;
    logic [SRC_W-1:0]     rr_q;
    entry_t               fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 high_prio_q;
    logic [7:0]           drop_cnt_q;
`ifdef RL_RAS_ARB_TIMESTAMP_EN
    logic [15:0]          tstamp_q;
`endif

    entry_t               new_entry [NUM_SRC];
    logic [NUM_SRC-1:0]   new_ev;
    logic [NUM_SRC-1:0]   new_fatal;
    logic [NUM_SRC-1:0]   slot_fatal;
    logic [NUM_SRC-1:0]   cand;
    logic [NUM_SRC-1:0]   grant_oh;
    logic [NUM_SRC-1:0]   cap;
    logic [NUM_SRC-1:0]   ovw;
    logic [NUM_SRC-1:0]   drop_vec;
    logic                 grant_found;
    logic [SRC_W-1:0]     grant_idx;
    entry_t               grant_entry;
    logic                 grant;
    logic                 pop;
    logic                 can_push;
    logic                 hp_next;
    logic [DSUM_W-1:0]    drop_sum;
    logic [8:0]           drop_total;
    entry_t               head;

    // Per-source decode of the incoming pulse; ADDR dominates DB dominates SB.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            new_ev[i]          = src_sb_err[i] | src_db_err[i] | src_addr_err[i];
            new_fatal[i]       = src_db_err[i] | src_addr_err[i];
            new_entry[i]       = '0;
            new_entry[i].src   = SRC_W'(i);
            new_entry[i].etype = src_addr_err[i] ? TYPE_ADDR :
                                 (src_db_err[i] ? TYPE_DB : TYPE_SB);
            new_entry[i].syn   = src_syndrome[i*SYN_W +: SYN_W];
            new_entry[i].addr  = src_addr[i*ADDR_W +: ADDR_W];
`ifdef RL_RAS_ARB_TIMESTAMP_EN
            new_entry[i].ts    = tstamp_q;
`endif
            slot_fatal[i]      = slot_full_q[i] & slot_q[i].etype[1];
        end
    end

    // Round-robin search from rr_q over the fatal slots if any, else over all full slots.
    always_comb begin
        int idx;
        cand        = (|slot_fatal) ? slot_fatal : slot_full_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_entry = '0;
        idx         = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!grant_found && cand[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(idx);
                grant_entry = slot_q[idx];
            end
        end
    end

    // Stream handshake: a record transfers on any cycle where evt_valid and evt_accept
    // are both high; while evt_valid is high without evt_accept the head is held.
    assign pop      = evt_valid & evt_accept;
    assign can_push = (count_q < CNT_W'(FIFO_DEPTH)) | pop;
    assign grant    = grant_found & can_push;

    // A slot granted this cycle counts as free, so a same-cycle event lands without loss.
    always_comb begin
        hp_next  = 1'b0;
        drop_sum = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            grant_oh[i] = grant && (grant_idx == SRC_W'(i));
            cap[i]      = new_ev[i] & (~slot_full_q[i] | grant_oh[i]);
            ovw[i]      = new_ev[i] & slot_full_q[i] & ~grant_oh[i] &
                          new_fatal[i] & ~slot_q[i].etype[1];
            drop_vec[i] = new_ev[i] & slot_full_q[i] & ~grant_oh[i];
            hp_next     = hp_next | ((cap[i] | ovw[i]) & new_fatal[i]);
            drop_sum    = drop_sum + DSUM_W'(drop_vec[i]);
        end
        drop_total = {1'b0, drop_cnt_q} + 9'(drop_sum);
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            slot_full_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cap[i] | ovw[i]) begin
                    slot_full_q[i] <= 1'b1;
                    slot_q[i]      <= new_entry[i];
                end else if (grant_oh[i]) begin
                    slot_full_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            rr_q <= '0;
        end else if (grant) begin
            rr_q <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (grant) begin
                fifo_q[wr_ptr_q] <= grant_entry;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (grant && !pop)      count_q <= count_q + 1'b1;
            else if (!grant && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            high_prio_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            high_prio_q <= hp_next;
            if (drop_clr)             drop_cnt_q <= '0;
            else if (drop_total[8])   drop_cnt_q <= 8'hFF;
            else                      drop_cnt_q <= drop_total[7:0];
        end
    end

`ifdef RL_RAS_ARB_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) tstamp_q <= '0;
        else        tstamp_q <= tstamp_q + 16'd1;
    end
`endif

    assign head         = fifo_q[rd_ptr_q];
    assign evt_valid    = (count_q != '0);
    assign evt_src      = head.src;
    assign evt_type     = head.etype;
    assign evt_syndrome = head.syn;
    assign evt_addr     = head.addr;
`ifdef RL_RAS_ARB_TIMESTAMP_EN
    assign evt_tstamp   = head.ts;
`endif
    assign high_prio    = high_prio_q;
    assign drop_cnt     = drop_cnt_q;

endmodule
